timestep_counter_n: RTL and testbench
=====================================

Name: timestep_counter_n

Overview:
- Parametrised successor of the processor's 2-bit timestep counter; sequences the control-unit timesteps T0..T(MAX_STEP) of each instruction.
- Adds:
  - configurable width and terminal step
  - early instruction termination (DONE)
  - stall/enable
  - preload
  - one-hot timestep decode
  - registered instruction-complete pulse
  - completed-instruction counter
- Sits between the instruction register/decoder and the control-signal generator; drives step selects and the fetch-enable of the next instruction.

Parameters:
- WIDTH, 2, bit width of timestep count CNT; legal range 1..6.
- MAX_STEP, 3, last timestep index before wrap to 0; must satisfy 0 < MAX_STEP <= 2**WIDTH-1 (elaboration-time assertion).
- ICW, 10, width of completed-instruction counter ICNT (matches 10-bit datapath).

Ports:
- CLKb, input, 1, system clock; all state updates on falling edge.
- CLRb, input, 1, asynchronous active-low reset.
- EN, input, 1, count enable; 0 holds all state.
- STALL, input, 1, pipeline/memory stall; 1 holds all state (same effect as EN=0).
- CLR, input, 1, synchronous active-high clear of CNT to 0 (instruction abort); ICNT untouched.
- DONE, input, 1, current instruction finishes at current step; next step is 0.
- LD, input, 1, synchronous load of CNT from LD_VAL.
- LD_VAL, input, WIDTH, preload value; clamped to MAX_STEP if larger.
- CNT, output, WIDTH, current timestep (registered).
- T, output, 2**WIDTH, one-hot decode of CNT; T[CNT]=1 (combinational from CNT register).
- TC, output, 1, CNT==MAX_STEP (combinational).
- IDONE, output, 1, registered one-cycle pulse: an instruction completed on the previous falling edge.
- ICNT, output, ICW, count of completed instructions; wraps modulo 2**ICW.
- ICOV, output, 1, sticky flag; set when ICNT wraps from all-ones to 0.

Behaviour:
- Reset: CLRb=0 asynchronously forces CNT=0, IDONE=0, ICNT=0, ICOV=0; T=1 (bit0), TC=0. Release is synchronised by the user; first update is the first falling edge with CLRb=1.
- Update priority per falling edge of CLKb (highest first):
  - 1. CLR=1: CNT<=0, IDONE<=0, ICNT/ICOV hold; CLR overrides EN/STALL.
  - 2. LD=1 (and not CLR): CNT<=min(LD_VAL,MAX_STEP), IDONE<=0; LD overrides EN/STALL.
  - 3. EN=0 or STALL=1: all registers hold, except IDONE<=0 (pulse never stretches).
  - 4. DONE=1 or CNT==MAX_STEP: "completion" — CNT<=0, IDONE<=1, ICNT<=ICNT+1; if ICNT was all-ones, ICOV<=1.
  - 5. Otherwise: CNT<=CNT+1, IDONE<=0.
- Completion fires once per edge even if DONE=1 and TC=1 simultaneously (ICNT +1, not +2).
- DONE=1 at CNT=0 is legal (single-step instruction): IDONE pulses every enabled edge while held.
- CNT never exceeds MAX_STEP; values MAX_STEP+1..2**WIDTH-1 are unreachable. T bits above MAX_STEP are always 0.
- ICOV clears only on CLRb; CLR does not clear it.
- Latency:
  - CNT/T/TC reflect an update immediately after the edge.
  - IDONE is high for exactly the cycle following the completing edge.
- With WIDTH=2, MAX_STEP=3, and DONE/LD/STALL tied inactive and EN=1, CNT behaviour is identical to the legacy counter (0,1,2,3,0…), except that the clear is now split into an async active-low reset (CLRb) and a separate synchronous clear (CLR).
- Reset mid-instruction: CLRb=0 asserted between edges takes effect immediately; no IDONE is generated.

Test Plan:
- 1. Free-run, defaults, EN=1: CLRb released, 9 falling edges -> CNT 1,2,3,0,1,2,3,0,1; IDONE high after edges 4 and 8 only; ICNT=2; T one-hot matches CNT each cycle.
- 2. Early finish, WIDTH=3, MAX_STEP=5: DONE=1 when CNT=2 -> next CNT=0, IDONE=1 one cycle, ICNT+1; DONE=1 with CNT=5 -> single increment of ICNT.
- 3. Stall/enable: CNT=2, STALL=1 for 3 edges then EN=0 for 2 edges -> CNT stays 2, IDONE=0; release -> CNT=3; stall on CNT=MAX_STEP defers completion until release.
- 4. Priority: CLR=1 and LD=1 with LD_VAL=2 at CNT=1 -> CNT=0; LD=1, LD_VAL=7 with WIDTH=3, MAX_STEP=5, STALL=1 -> CNT=5, TC=1.
- 5. ICNT wrap, ICW=3: 8 completions -> ICNT=0, ICOV=1; CLR pulse -> ICOV stays 1; CLRb pulse -> ICOV=0.
- 6. Async reset between edges at CNT=3: CNT=0 and T=0001 immediately, no IDONE; first edge after release -> CNT=1.

Source files
------------

// File: rtl/timestep_counter_n_if.sv
// Control/status bundle of the timestep counter: sequencing requests from the
// decoder side and step/completion status toward the control-signal generator.
interface timestep_counter_n_if #(
  parameter int WIDTH = 2,
  parameter int ICW   = 10
);
  logic                    EN;
  logic                    STALL;
  logic                    CLR;
  logic                    DONE;
  logic                    LD;
  logic [WIDTH-1:0]        LD_VAL;
  logic [WIDTH-1:0]        CNT;
  logic [(2**WIDTH)-1:0]   T;
  logic                    TC;
  logic                    IDONE;
  logic [ICW-1:0]          ICNT;
  logic                    ICOV;

  modport master (
    output EN, STALL, CLR, DONE, LD, LD_VAL,
    input  CNT, T, TC, IDONE, ICNT, ICOV
  );

  modport slave (
    input  EN, STALL, CLR, DONE, LD, LD_VAL,
    output CNT, T, TC, IDONE, ICNT, ICOV
  );
endinterface

// File: rtl/timestep_counter_n.sv
// Parametrised instruction timestep sequencer T0..T(MAX_STEP) with early finish,
// stall, preload, one-hot step decode and a completed-instruction counter.
module timestep_counter_n_chk #(
  parameter int WIDTH    = 2,
  parameter int MAX_STEP = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  input logic [WIDTH-1:0]      cnt,
  input logic [(2**WIDTH)-1:0] t
);
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_STEP);

  generate
    if ((WIDTH < 1) || (WIDTH > 6) || (MAX_STEP < 1) || (MAX_STEP > (2**WIDTH) - 1)) begin : g_bad_cfg
      $error("timestep_counter_n: illegal WIDTH/MAX_STEP combination");
    end
  endgenerate

  a_cnt_range: assert property (@(negedge clk) disable iff (!rst_n) cnt <= MAX_CNT);
  a_t_onehot:  assert property (@(negedge clk) disable iff (!rst_n) $onehot(t));
endmodule

module timestep_counter_n #(
  parameter int WIDTH    = 2,
  parameter int MAX_STEP = 3,
  parameter int ICW      = 10
) (
  input logic                  CLKb,
  input logic                  CLRb,
  timestep_counter_n_if.slave  bus
);
  localparam int               NSTEP   = 2**WIDTH;
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_STEP);

  logic [WIDTH-1:0] cnt_r;
  logic             idone_r;
  logic [ICW-1:0]   icnt_r;
  logic             icov_r;

  logic [WIDTH-1:0] cnt_nxt_s;
  logic             idone_nxt_s;
  logic [ICW-1:0]   icnt_nxt_s;
  logic             icov_nxt_s;
  logic             tc_s;
  logic             complete_s;
  logic             hold_s;

  function automatic logic [WIDTH-1:0] clamp_step(input logic [WIDTH-1:0] v);
    if (v > MAX_CNT) begin
      return MAX_CNT;
    end else begin
      return v;
    end
  endfunction

  // Bits above MAX_STEP are forced low so unreachable steps can never select.
  function automatic logic [NSTEP-1:0] decode_step(input logic [WIDTH-1:0] v);
    logic [NSTEP-1:0] d;
    d = {NSTEP{1'b0}};
    for (int i = 0; i < NSTEP; i++) begin
      d[i] = (i <= MAX_STEP) && (v == WIDTH'(i));
    end
    return d;
  endfunction

  assign tc_s       = (cnt_r == MAX_CNT);
  assign complete_s = bus.DONE || tc_s;
  assign hold_s     = !bus.EN || bus.STALL;

  // Next-state selection: clear, then load, then hold, then completion, then advance.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    idone_nxt_s = 1'b0;
    icnt_nxt_s  = icnt_r;
    icov_nxt_s  = icov_r;
    if (bus.CLR) begin
      cnt_nxt_s = {WIDTH{1'b0}};
    end else if (bus.LD) begin
      cnt_nxt_s = clamp_step(bus.LD_VAL);
    end else if (hold_s) begin
      cnt_nxt_s = cnt_r;
    end else if (complete_s) begin
      cnt_nxt_s   = {WIDTH{1'b0}};
      idone_nxt_s = 1'b1;
      icnt_nxt_s  = icnt_r + ICW'(1);
      if (icnt_r == {ICW{1'b1}}) begin
        icov_nxt_s = 1'b1;
      end else begin
        icov_nxt_s = icov_r;
      end
    end else begin
      cnt_nxt_s = cnt_r + WIDTH'(1);
    end
  end

  // State registers, updated on the falling clock edge.
  always_ff @(negedge CLKb or negedge CLRb) begin
    if (!CLRb) begin
      cnt_r   <= {WIDTH{1'b0}};
      idone_r <= 1'b0;
      icnt_r  <= {ICW{1'b0}};
      icov_r  <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      idone_r <= idone_nxt_s;
      icnt_r  <= icnt_nxt_s;
      icov_r  <= icov_nxt_s;
    end
  end

  assign bus.CNT   = cnt_r;
  assign bus.T     = decode_step(cnt_r);
  assign bus.TC    = tc_s;
  assign bus.IDONE = idone_r;
  assign bus.ICNT  = icnt_r;
  assign bus.ICOV  = icov_r;

  timestep_counter_n_chk #(
    .WIDTH    (WIDTH),
    .MAX_STEP (MAX_STEP)
  ) u_chk (
    .clk   (CLKb),
    .rst_n (CLRb),
    .cnt   (cnt_r),
    .t     (bus.T)
  );
endmodule

// File: tb/tb_timestep_counter_n.sv
// Directed bench: a default counter (A) and a WIDTH=3/MAX_STEP=5/ICW=3 counter (B).
module tb_timestep_counter_n;
  logic clk = 1'b1;
  logic rst_a_n = 1'b0;
  logic rst_b_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  timestep_counter_n_if #(.WIDTH(2), .ICW(10)) bus_a ();
  timestep_counter_n_if #(.WIDTH(3), .ICW(3))  bus_b ();

  timestep_counter_n #(.WIDTH(2), .MAX_STEP(3), .ICW(10)) dut_a (
    .CLKb (clk), .CLRb (rst_a_n), .bus (bus_a.slave)
  );
  timestep_counter_n #(.WIDTH(3), .MAX_STEP(5), .ICW(3)) dut_b (
    .CLKb (clk), .CLRb (rst_b_n), .bus (bus_b.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_a.EN = 1'b0; bus_a.STALL = 1'b0; bus_a.CLR = 1'b0;
    bus_a.DONE = 1'b0; bus_a.LD = 1'b0; bus_a.LD_VAL = 2'd0;
    bus_b.EN = 1'b0; bus_b.STALL = 1'b0; bus_b.CLR = 1'b0;
    bus_b.DONE = 1'b0; bus_b.LD = 1'b0; bus_b.LD_VAL = 3'd0;
    #1;
    checks++; if (bus_a.CNT !== 2'd0) begin errors++; $display("FAIL reset_cnt_a: got %0d expected 0", bus_a.CNT); end
    checks++; if (bus_a.T !== 4'b0001) begin errors++; $display("FAIL reset_t_a: got %b expected 0001", bus_a.T); end
    checks++; if (bus_a.TC !== 1'b0) begin errors++; $display("FAIL reset_tc_a: got %b expected 0", bus_a.TC); end
    checks++; if (bus_a.IDONE !== 1'b0) begin errors++; $display("FAIL reset_idone_a: got %b expected 0", bus_a.IDONE); end
    checks++; if (bus_a.ICNT !== 10'd0) begin errors++; $display("FAIL reset_icnt_a: got %0d expected 0", bus_a.ICNT); end
    checks++; if (bus_a.ICOV !== 1'b0) begin errors++; $display("FAIL reset_icov_a: got %b expected 0", bus_a.ICOV); end
    checks++; if (bus_b.T !== 8'b0000_0001) begin errors++; $display("FAIL reset_t_b: got %b expected 00000001", bus_b.T); end
  endtask

  task automatic test_free_run();
    int exp_cnt [9] = '{1, 2, 3, 0, 1, 2, 3, 0, 1};
    logic [3:0] exp_t;
    bus_a.EN = 1'b1;
    @(posedge clk);
    rst_a_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_t = 4'b0001 << exp_cnt[i];
      checks++; if (bus_a.CNT !== 2'(exp_cnt[i])) begin errors++; $display("FAIL free_run_cnt edge %0d: got %0d expected %0d", i + 1, bus_a.CNT, exp_cnt[i]); end
      checks++; if (bus_a.T !== exp_t) begin errors++; $display("FAIL free_run_t edge %0d: got %b expected %b", i + 1, bus_a.T, exp_t); end
      checks++; if (bus_a.IDONE !== ((i == 3) || (i == 7))) begin errors++; $display("FAIL free_run_idone edge %0d: got %b", i + 1, bus_a.IDONE); end
      checks++; if (bus_a.TC !== (exp_cnt[i] == 3)) begin errors++; $display("FAIL free_run_tc edge %0d: got %b", i + 1, bus_a.TC); end
    end
    checks++; if (bus_a.ICNT !== 10'd2) begin errors++; $display("FAIL free_run_icnt: got %0d expected 2", bus_a.ICNT); end
    bus_a.EN = 1'b0;
  endtask

  task automatic test_early_done();
    bus_b.EN = 1'b1;
    @(posedge clk);
    rst_b_n = 1'b1;
    tick(); tick();
    checks++; if (bus_b.CNT !== 3'd2) begin errors++; $display("FAIL early_pre_cnt: got %0d expected 2", bus_b.CNT); end
    bus_b.DONE = 1'b1;
    tick();
    bus_b.DONE = 1'b0;
    checks++; if (bus_b.CNT !== 3'd0) begin errors++; $display("FAIL early_cnt: got %0d expected 0", bus_b.CNT); end
    checks++; if (bus_b.IDONE !== 1'b1) begin errors++; $display("FAIL early_idone: got %b expected 1", bus_b.IDONE); end
    checks++; if (bus_b.ICNT !== 3'd1) begin errors++; $display("FAIL early_icnt: got %0d expected 1", bus_b.ICNT); end
    tick();
    checks++; if (bus_b.IDONE !== 1'b0) begin errors++; $display("FAIL early_idone_drop: got %b expected 0", bus_b.IDONE); end
    checks++; if (bus_b.CNT !== 3'd1) begin errors++; $display("FAIL early_restart: got %0d expected 1", bus_b.CNT); end
    tick(); tick(); tick(); tick();
    checks++; if ((bus_b.CNT !== 3'd5) || (bus_b.TC !== 1'b1)) begin errors++; $display("FAIL early_at_max: got cnt %0d tc %b expected 5/1", bus_b.CNT, bus_b.TC); end
    bus_b.DONE = 1'b1;
    tick();
    checks++; if (bus_b.ICNT !== 3'd2) begin errors++; $display("FAIL done_and_tc_icnt: got %0d expected 2", bus_b.ICNT); end
    checks++; if ((bus_b.CNT !== 3'd0) || (bus_b.IDONE !== 1'b1)) begin errors++; $display("FAIL done_and_tc_cnt: got cnt %0d idone %b expected 0/1", bus_b.CNT, bus_b.IDONE); end
    tick();
    checks++; if ((bus_b.CNT !== 3'd0) || (bus_b.IDONE !== 1'b1) || (bus_b.ICNT !== 3'd3)) begin errors++; $display("FAIL single_step_1: got cnt %0d idone %b icnt %0d expected 0/1/3", bus_b.CNT, bus_b.IDONE, bus_b.ICNT); end
    tick();
    checks++; if ((bus_b.IDONE !== 1'b1) || (bus_b.ICNT !== 3'd4)) begin errors++; $display("FAIL single_step_2: got idone %b icnt %0d expected 1/4", bus_b.IDONE, bus_b.ICNT); end
    bus_b.DONE = 1'b0;
    bus_b.EN = 1'b0;
  endtask

  task automatic test_stall();
    bus_a.EN = 1'b1;
    tick();
    checks++; if (bus_a.CNT !== 2'd2) begin errors++; $display("FAIL stall_pre: got %0d expected 2", bus_a.CNT); end
    bus_a.STALL = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ((bus_a.CNT !== 2'd2) || (bus_a.IDONE !== 1'b0)) begin errors++; $display("FAIL stall_hold %0d: got cnt %0d idone %b expected 2/0", i, bus_a.CNT, bus_a.IDONE); end
    end
    bus_a.STALL = 1'b0;
    bus_a.EN = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (bus_a.CNT !== 2'd2) begin errors++; $display("FAIL en_hold %0d: got %0d expected 2", i, bus_a.CNT); end
    end
    bus_a.EN = 1'b1;
    tick();
    checks++; if ((bus_a.CNT !== 2'd3) || (bus_a.TC !== 1'b1)) begin errors++; $display("FAIL stall_release: got cnt %0d tc %b expected 3/1", bus_a.CNT, bus_a.TC); end
    bus_a.STALL = 1'b1;
    tick(); tick();
    checks++; if ((bus_a.CNT !== 2'd3) || (bus_a.IDONE !== 1'b0) || (bus_a.ICNT !== 10'd2)) begin errors++; $display("FAIL stall_at_max: got cnt %0d idone %b icnt %0d expected 3/0/2", bus_a.CNT, bus_a.IDONE, bus_a.ICNT); end
    bus_a.STALL = 1'b0;
    tick();
    checks++; if ((bus_a.CNT !== 2'd0) || (bus_a.IDONE !== 1'b1) || (bus_a.ICNT !== 10'd3)) begin errors++; $display("FAIL deferred_completion: got cnt %0d idone %b icnt %0d expected 0/1/3", bus_a.CNT, bus_a.IDONE, bus_a.ICNT); end
    bus_a.STALL = 1'b1;
    tick();
    checks++; if ((bus_a.IDONE !== 1'b0) || (bus_a.CNT !== 2'd0)) begin errors++; $display("FAIL idone_no_stretch: got idone %b cnt %0d expected 0/0", bus_a.IDONE, bus_a.CNT); end
    bus_a.STALL = 1'b0;
    bus_a.EN = 1'b0;
  endtask

  task automatic test_priority();
    bus_a.EN = 1'b1;
    tick();
    checks++; if (bus_a.CNT !== 2'd1) begin errors++; $display("FAIL prio_pre: got %0d expected 1", bus_a.CNT); end
    bus_a.CLR = 1'b1; bus_a.LD = 1'b1; bus_a.LD_VAL = 2'd2;
    tick();
    checks++; if ((bus_a.CNT !== 2'd0) || (bus_a.ICNT !== 10'd3) || (bus_a.IDONE !== 1'b0)) begin errors++; $display("FAIL clr_over_ld: got cnt %0d icnt %0d idone %b expected 0/3/0", bus_a.CNT, bus_a.ICNT, bus_a.IDONE); end
    bus_a.CLR = 1'b0; bus_a.EN = 1'b0;
    tick();
    checks++; if (bus_a.CNT !== 2'd2) begin errors++; $display("FAIL ld_over_en: got %0d expected 2", bus_a.CNT); end
    bus_a.LD = 1'b0;
    bus_b.LD = 1'b1; bus_b.LD_VAL = 3'd7; bus_b.STALL = 1'b1;
    tick();
    checks++; if ((bus_b.CNT !== 3'd5) || (bus_b.TC !== 1'b1)) begin errors++; $display("FAIL ld_clamp: got cnt %0d tc %b expected 5/1", bus_b.CNT, bus_b.TC); end
    checks++; if (bus_b.T !== 8'b0010_0000) begin errors++; $display("FAIL ld_clamp_t: got %b expected 00100000", bus_b.T); end
    bus_b.LD = 1'b0; bus_b.STALL = 1'b0; bus_b.EN = 1'b1;
    tick();
    checks++; if ((bus_b.CNT !== 3'd0) || (bus_b.IDONE !== 1'b1) || (bus_b.ICNT !== 3'd5)) begin errors++; $display("FAIL ld_then_complete: got cnt %0d idone %b icnt %0d expected 0/1/5", bus_b.CNT, bus_b.IDONE, bus_b.ICNT); end
    bus_b.EN = 1'b0;
  endtask

  task automatic test_icnt_wrap();
    @(posedge clk);
    rst_b_n = 1'b0;
    #1;
    checks++; if (bus_b.ICNT !== 3'd0) begin errors++; $display("FAIL wrap_reset_icnt: got %0d expected 0", bus_b.ICNT); end
    @(posedge clk);
    rst_b_n = 1'b1;
    bus_b.EN = 1'b1; bus_b.DONE = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++; if ((bus_b.ICNT !== 3'd7) || (bus_b.ICOV !== 1'b0)) begin errors++; $display("FAIL wrap_pre: got icnt %0d icov %b expected 7/0", bus_b.ICNT, bus_b.ICOV); end
    tick();
    checks++; if ((bus_b.ICNT !== 3'd0) || (bus_b.ICOV !== 1'b1)) begin errors++; $display("FAIL wrap: got icnt %0d icov %b expected 0/1", bus_b.ICNT, bus_b.ICOV); end
    bus_b.DONE = 1'b0; bus_b.CLR = 1'b1;
    tick();
    bus_b.CLR = 1'b0;
    checks++; if ((bus_b.ICOV !== 1'b1) || (bus_b.CNT !== 3'd0)) begin errors++; $display("FAIL clr_keeps_icov: got icov %b cnt %0d expected 1/0", bus_b.ICOV, bus_b.CNT); end
    bus_b.EN = 1'b0;
    @(posedge clk);
    rst_b_n = 1'b0;
    #1;
    checks++; if (bus_b.ICOV !== 1'b0) begin errors++; $display("FAIL clrb_clears_icov: got %b expected 0", bus_b.ICOV); end
    @(posedge clk);
    rst_b_n = 1'b1;
  endtask

  task automatic test_async_reset();
    bus_a.EN = 1'b1;
    tick();
    checks++; if (bus_a.CNT !== 2'd3) begin errors++; $display("FAIL async_pre: got %0d expected 3", bus_a.CNT); end
    @(posedge clk);
    rst_a_n = 1'b0;
    #1;
    checks++; if ((bus_a.CNT !== 2'd0) || (bus_a.T !== 4'b0001) || (bus_a.TC !== 1'b0)) begin errors++; $display("FAIL async_immediate: got cnt %0d t %b tc %b expected 0/0001/0", bus_a.CNT, bus_a.T, bus_a.TC); end
    checks++; if ((bus_a.IDONE !== 1'b0) || (bus_a.ICNT !== 10'd0)) begin errors++; $display("FAIL async_no_idone: got idone %b icnt %0d expected 0/0", bus_a.IDONE, bus_a.ICNT); end
    tick();
    checks++; if ((bus_a.IDONE !== 1'b0) || (bus_a.CNT !== 2'd0)) begin errors++; $display("FAIL async_held: got idone %b cnt %0d expected 0/0", bus_a.IDONE, bus_a.CNT); end
    @(posedge clk);
    rst_a_n = 1'b1;
    tick();
    checks++; if ((bus_a.CNT !== 2'd1) || (bus_a.IDONE !== 1'b0)) begin errors++; $display("FAIL async_first_edge: got cnt %0d idone %b expected 1/0", bus_a.CNT, bus_a.IDONE); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_early_done();
    test_stall();
    test_priority();
    test_icnt_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
